// File: rtl/poly_mult_stream_ctrl_if.sv
// Coefficient-serial handshake bundle between a stream source/sink and the
// polynomial-multiplier stream controller.
interface poly_mult_stream_ctrl_if #(
  parameter int N = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/poly_mult_stream_ctrl.sv
// Stream controller for a negacyclic polynomial multiplier array: loads operands
// a and b one coefficient at a time, waits LAT cycles, then streams the product.
module poly_mult_stream_ctrl #(
  parameter int D   = 4,
  parameter int N   = 4,
  parameter int LAT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  poly_mult_stream_ctrl_if.slave bus,
  output logic [D*N-1:0]         horz,
  output logic [D*N-1:0]         vert,
  input  logic [D*N-1:0]         p,
  output logic                   busy
);
  localparam int KW = $clog2(D) + 1;
  localparam int WW = $clog2(LAT) + 1;
  localparam logic [KW-1:0] K_LAST = KW'(D - 1);
  localparam logic [WW-1:0] W_LAST = WW'(LAT - 1);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, RUN, DRAIN} state_e;

  state_e         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [WW-1:0]  wait_q, wait_d;
  logic [D*N-1:0] horz_q, horz_d;
  logic [D*N-1:0] vert_q, vert_d;
  logic [D*N-1:0] prod_q, prod_d;

  logic in_rdy, out_vld, in_xfer, out_xfer;

  // Handshake qualifiers are gated by rst so the ports read idle during reset.
  assign in_rdy   = ~rst & ((state_q == LOAD_A) || (state_q == LOAD_B));
  assign out_vld  = ~rst & (state_q == DRAIN);
  assign in_xfer  = in_rdy & bus.in_valid;
  assign out_xfer = out_vld & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD_A;
      k_q     <= '0;
      wait_q  <= '0;
      horz_q  <= '0;
      vert_q  <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      wait_q  <= wait_d;
      horz_q  <= horz_d;
      vert_q  <= vert_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    wait_d  = wait_q;
    horz_d  = horz_q;
    vert_d  = vert_q;
    prod_d  = prod_q;
    unique case (state_q)
      LOAD_A: begin
        // a[0] lands in the most-significant slice of horz.
        if (in_xfer) begin
          horz_d[N*(D-1-int'(k_q)) +: N] = bus.in_data;
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = LOAD_B;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      LOAD_B: begin
        if (in_xfer) begin
          vert_d[N*int'(k_q) +: N] = bus.in_data;
          if (k_q == K_LAST) begin
            k_d     = '0;
            wait_d  = '0;
            state_d = RUN;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      RUN: begin
        if (wait_q == W_LAST) begin
          prod_d  = p;
          wait_d  = '0;
          state_d = DRAIN;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      DRAIN: begin
        if (out_xfer) begin
          if (k_q == K_LAST) begin
            k_d     = '0;
            state_d = LOAD_A;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = LOAD_A;
        k_d     = '0;
        wait_d  = '0;
      end
    endcase
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_data  = out_vld ? prod_q[N*int'(k_q) +: N] : '0;
  assign bus.out_last  = out_vld & (k_q == K_LAST);
  assign horz          = horz_q;
  assign vert          = vert_q;
  assign busy          = ~((state_q == LOAD_A) && (k_q == '0));
endmodule

// File: doc/poly_mult_stream_ctrl.md
POLY_MULT_STREAM_CTRL -- requirements
Module: poly_mult_stream_ctrl

Interface
REQ-001 SHALL have parameter D, default 4, meaning polynomial degree (coefficients per operand).
REQ-002 SHALL have parameter N, default 4, meaning coefficient width in bits (arithmetic mod 2^N).
REQ-003 SHALL have parameter LAT, default 8, meaning cycles the block waits after launching operands before it samples p; LAT >= 1.
REQ-004 SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have the port in_valid, input, 1 bit: in_data holds a valid coefficient.
REQ-007 SHALL have the port in_ready, output, 1 bit: the block accepts a coefficient this cycle.
REQ-008 SHALL have the port in_data, input, N bits: one coefficient.
REQ-009 SHALL have the port out_valid, output, 1 bit: out_data holds a valid product coefficient.
REQ-010 SHALL have the port out_ready, input, 1 bit: the sink accepts out_data.
REQ-011 SHALL have the port out_data, output, N bits: one product coefficient.
REQ-012 SHALL have the port out_last, output, 1 bit: high with product coefficient D-1.
REQ-013 SHALL have the port horz, output, D*N bits: operand a, sent to the multiplier array.
REQ-014 SHALL have the port vert, output, D*N bits: operand b, sent to the multiplier array.
REQ-015 SHALL have the port p, input, D*N bits: product a*b mod (x^D+1), from the multiplier array.
REQ-016 SHALL have the port busy, output, 1 bit: high in every state except LOAD_A with zero coefficients loaded.

Function
REQ-017 SHALL implement FSM states LOAD_A, LOAD_B, RUN, DRAIN, with a coefficient counter k of width clog2(D)+1.
REQ-018 A transfer on either stream SHALL occur only on a cycle where valid and ready are both high.
REQ-019 In LOAD_A, in_ready=1, and each transfer SHALL write coefficient a[k] into horz[N*(D-k)-1:N*(D-1-k)] (a[0] in the top slice), then increment k.
REQ-020 On the transfer with k=D-1 in LOAD_A, the FSM SHALL clear k and go to LOAD_B.
REQ-021 In LOAD_B, in_ready=1, and each transfer SHALL write b[k] into vert[N*(k+1)-1:N*k]; on k=D-1 it SHALL clear k and go to RUN.
REQ-022 In RUN, in_ready=0, horz and vert SHALL be held stable, and a wait counter SHALL count LAT cycles.
REQ-023 On the last RUN cycle, the block SHALL capture all of p into an internal D*N product register and go to DRAIN.
REQ-024 In DRAIN, out_valid=1 and out_data=product[N*(k+1)-1:N*k], with coefficient 0 first.
REQ-025 In DRAIN, k SHALL advance only on an out_ready transfer.
REQ-026 While out_ready=0 in DRAIN, out_data and out_last SHALL be held unchanged.
REQ-027 out_last SHALL be 1 only in DRAIN with k=D-1.
REQ-028 After that transfer, the FSM SHALL clear k and return to LOAD_A.
REQ-029 In LOAD_A and LOAD_B, out_valid SHALL be 0; in DRAIN, in_ready SHALL be 0.
REQ-030 Input bubbles (in_valid=0) SHALL stall loading with no state change.
REQ-031 in_valid is ignored whenever in_ready=0.
REQ-032 horz and vert SHALL keep the previous operands until they are overwritten coefficient by coefficient in the next LOAD phase.
REQ-033 No arithmetic is done in this block; coefficients pass through bit-exact.
REQ-034 Throughput SHALL be one product per 2D+LAT+D cycles when both streams flow with no stalls.

Reset
REQ-035 While rst=1, state SHALL be LOAD_A, k=0, wait counter=0, and horz=vert=product=0.
REQ-036 While rst=1, out_valid=0, out_last=0, out_data=0, busy=0; in_ready SHALL also be 0.
REQ-037 in_ready SHALL rise in the first cycle after rst deasserts.
REQ-038 A reset in any state, including mid-RUN or mid-DRAIN, SHALL abort the operation; partial operands and pending outputs are discarded, and no output beat is emitted afterward.

Verification (D=4, N=4, LAT=8; the bench connects a behavioural negacyclic multiplier with latency <= LAT)
REQ-039 Stream a=1,0,0,0 then b=1,2,3,4, with out_ready=1 -> out_data 1,2,3,4 on consecutive cycles, out_last on the 4th beat, and the first beat 9 cycles after the last b transfer.
REQ-040 Stream a=0,1,0,0 then b=1,2,3,4 -> out_data 12,1,2,3 (the -4 wraps mod 16).
REQ-041 Stream a=15,15,15,15 and b=1,0,0,0 -> 15,15,15,15; also check horz=16'hFFFF and vert=16'h0001 held for all 8 RUN cycles.
REQ-042 Hold out_ready=0 for 5 cycles during DRAIN -> out_valid stays 1, the beat repeats unchanged, in_ready=0, and no beat is lost or duplicated.
REQ-043 Randomly toggle in_valid during loading, then pulse rst in the 3rd RUN cycle -> all outputs are 0 in the same cycle, no DRAIN beats appear, and the next full operand pair produces the correct product.
